bcd_addsub_seq: RTL
===================

# bcd_addsub_seq

Parametrised multi-digit BCD adder/subtractor that processes one decimal digit per clock, least-significant digit first, under a start/done handshake. It replaces the fixed two-digit, single-cycle BCD add stage in the calculator datapath. Subtraction is signed-magnitude: a negative difference is returned as its magnitude plus a sign flag. Inputs are checked for illegal BCD digits.

## Interface
- NUM_DIGITS, 4, number of BCD digits per operand and per result (≥1)
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  request; sampled only in IDLE
- sub  in  1  0 = a+b, 1 = a−b; captured with start
- a_bcd  in  4*NUM_DIGITS  operand A, digit i at [4i+3:4i]
- b_bcd  in  4*NUM_DIGITS  operand B
- result  out  4*NUM_DIGITS  BCD result; held until the next accepted start
- cout  out  1  add: sum ≥ 10^NUM_DIGITS (result holds the low digits); sub: 0
- neg  out  1  sub: a<b (result = b−a); add: 0
- err  out  1  an input digit was >9
- busy  out  1  high in RUN, FIX, DONE
- done  out  1  one-cycle pulse; result and flags valid

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE, start=1:
  - Latch a, b and sub. Clear result, cout, neg and err. cnt←0.
  - Carry c←sub. In sub mode each B digit is replaced by 9−b_i (nine's complement + 1 = ten's complement).
  - If any a_i or b_i >9: err←1, result stays 0, go to DONE.
  - Otherwise go to RUN.
- RUN, one digit per cycle:
  - s = a_i + b'_i + c, 5 bits.
  - If s≥10: digit = s−10 and c←1. Otherwise digit = s and c←0.
  - Write the digit into result[cnt] and increment cnt.
  - After digit NUM_DIGITS−1:
    - add: cout←c, go to DONE.
    - sub with c=1: neg←0, go to DONE.
    - sub with c=0: neg←1, cnt←0, c←1, go to FIX.
- FIX, one digit per cycle: replace each result digit r_i with (9−r_i)+c, using the same decimal-correction rule. After the last digit go to DONE. The final carry is discarded.
- DONE: done=1 for exactly one cycle, then IDLE.
- start is ignored in RUN, FIX and DONE. There is no queueing.
- Reset at any point, including mid-RUN or mid-FIX: state=IDLE, and result, cout, neg, err, busy, done are all 0.

## Timing
- start is sampled at edge T.
- Invalid input: DONE follows edge T, so done is high in cycle T+1.
- Add, or sub with a≥b: RUN covers edges T+1..T+N and done is high in cycle T+N+1. Latency N+1.
- Sub with a<b: FIX covers edges T+N+1..T+2N and done is high in cycle T+2N+1. Latency 2N+1.
- A new start is accepted no earlier than the edge that ends DONE, because the FSM has returned to IDLE.
- Intermediate result digits are visible while busy and are not valid until done.
- Every output is a register or a pure decode of state. There is no combinational path from inputs to outputs.

## Structure
- Package bcd_pkg holds:
  - the state enum (IDLE, RUN, FIX, DONE);
  - the constant BCD_W=4;
  - the constant BCD_TEN=10;
  - the function is_bcd(digit).
- Sub-module bcd_digit_add: a combinational single-digit add with carry-in.
  - Ports: x[3:0], y[3:0], ci → s[3:0], co.
  - One instance is shared by RUN and FIX. Operand muxing selects a_i/b'_i in RUN and 0/(9−r_i) in FIX.
- The digit counter is $clog2(NUM_DIGITS) bits wide, with a minimum of 1.

## Test plan
All cases use NUM_DIGITS=4.
- 1234 + 5678 → result 6912, cout 0, done in cycle T+5, busy high for 5 cycles.
- 9999 + 0001 → result 0000, cout 1. 0000 + 0000 → result 0000, cout 0.
- sub 5000 − 1234 → result 3766, neg 0, latency 5. Sub 1234 − 1234 → result 0000, neg 0.
- sub 1234 − 5000 → result 3766, neg 1, done in cycle T+9. Sub 0000 − 0001 → result 0001, neg 1.
- a = 0x12A4 → err 1, result 0000, done in cycle T+1. A second start pulsed while busy is ignored, and exactly one done pulse occurs.
- rst_n low during cycle 3 of a RUN → all outputs 0 immediately. After release, a fresh 0042 + 0058 → 0100 completes normally.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential BCD adder/subtractor.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int BCD_W   = 4;
  localparam int BCD_TEN = 10;

  // A nibble is a legal decimal digit only in the range 0..9.
  function automatic logic is_bcd(input logic [BCD_W-1:0] digit);
    return (digit < 4'(BCD_TEN));
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single decimal digit adder with carry-in and decimal correction.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] x,
  input  logic [BCD_W-1:0] y,
  input  logic             ci,
  output logic [BCD_W-1:0] s,
  output logic             co
);

  logic [BCD_W:0] raw;

  // Binary add, then fold anything of ten or more back into one digit plus a carry.
  always_comb begin
    raw = {1'b0, x} + {1'b0, y} + {{BCD_W{1'b0}}, ci};
    if (raw >= 5'(BCD_TEN)) begin
      s  = 4'(raw - 5'(BCD_TEN));
      co = 1'b1;
    end else begin
      s  = raw[BCD_W-1:0];
      co = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_addsub_seq.sv
// Multi-digit BCD add/subtract, one digit per clock, least significant first.
// A negative difference is recovered as a magnitude by a second ten's-complement pass.
module bcd_addsub_seq
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        sub,
  input  logic [BCD_W*NUM_DIGITS-1:0] a_bcd,
  input  logic [BCD_W*NUM_DIGITS-1:0] b_bcd,
  output logic [BCD_W*NUM_DIGITS-1:0] result,
  output logic                        cout,
  output logic                        neg,
  output logic                        err,
  output logic                        busy,
  output logic                        done
);

  localparam int W  = BCD_W * NUM_DIGITS;
  localparam int CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_DIGITS - 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           carry_q, carry_d;
  logic           sub_q, sub_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   result_q, result_d;
  logic           cout_q, cout_d;
  logic           neg_q, neg_d;
  logic           err_q, err_d;

  logic [W-1:0]     bComp;
  logic             inputsOk;
  logic [BCD_W-1:0] aDig, bDig, rDig;
  logic [BCD_W-1:0] addX, addY, addS;
  logic             addCo;

  // Validate incoming digits and form the nine's complement of B for subtraction.
  always_comb begin
    inputsOk = 1'b1;
    bComp    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!is_bcd(a_bcd[i*BCD_W +: BCD_W]) || !is_bcd(b_bcd[i*BCD_W +: BCD_W])) begin
        inputsOk = 1'b0;
      end
      bComp[i*BCD_W +: BCD_W] = 4'd9 - b_bcd[i*BCD_W +: BCD_W];
    end
  end

  // RUN adds the operand digits; FIX complements the stored result digit and adds the carry.
  always_comb begin
    aDig = a_q[int'(cnt_q)*BCD_W +: BCD_W];
    bDig = b_q[int'(cnt_q)*BCD_W +: BCD_W];
    rDig = result_q[int'(cnt_q)*BCD_W +: BCD_W];
    if (state_q == FIX) begin
      addX = '0;
      addY = 4'd9 - rDig;
    end else begin
      addX = aDig;
      addY = bDig;
    end
  end

  bcd_digit_add uDigitAdd (
    .x  (addX),
    .y  (addY),
    .ci (carry_q),
    .s  (addS),
    .co (addCo)
  );

  // Sequencing: accept a request, walk the digits, optionally fix up a negative result.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    sub_d    = sub_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cout_d   = cout_q;
    neg_d    = neg_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = a_bcd;
          b_d      = sub ? bComp : b_bcd;
          sub_d    = sub;
          carry_d  = sub;
          cnt_d    = '0;
          result_d = '0;
          cout_d   = 1'b0;
          neg_d    = 1'b0;
          err_d    = !inputsOk;
          state_d  = inputsOk ? RUN : DONE;
        end
      end
      RUN: begin
        result_d[int'(cnt_q)*BCD_W +: BCD_W] = addS;
        cnt_d   = cnt_q + 1'b1;
        carry_d = addCo;
        if (cnt_q == LAST) begin
          if (!sub_q) begin
            cout_d  = addCo;
            state_d = DONE;
          end else if (addCo) begin
            neg_d   = 1'b0;
            state_d = DONE;
          end else begin
            neg_d   = 1'b1;
            cnt_d   = '0;
            carry_d = 1'b1;
            state_d = FIX;
          end
        end
      end
      FIX: begin
        result_d[int'(cnt_q)*BCD_W +: BCD_W] = addS;
        cnt_d   = cnt_q + 1'b1;
        carry_d = addCo;
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset returns everything to an idle, zeroed machine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      sub_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      sub_q    <= sub_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      neg_q    <= neg_d;
      err_q    <= err_d;
    end
  end

  assign result = result_q;
  assign cout   = cout_q;
  assign neg    = neg_q;
  assign err    = err_q;
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);

endmodule
